// File: rtl/reset_request_ctrl_if.sv
// rtl/reset_request_ctrl_if.sv - request sources and reset-request outputs of reset_request_ctrl
interface reset_request_ctrl_if;
    logic       btnIn;
    logic       swReq;
    logic       wdtEn;
    logic       wdtKick;
    logic       causeClr;
    logic       rstReq;
    logic [2:0] cause;
    logic       busy;

    modport master (
        output btnIn, swReq, wdtEn, wdtKick, causeClr,
        input  rstReq, cause, busy
    );

    modport slave (
        input  btnIn, swReq, wdtEn, wdtKick, causeClr,
        output rstReq, cause, busy
    );
endinterface

// File: rtl/reset_request_ctrl.sv
// rtl/reset_request_ctrl.sv - merges button/software/watchdog requests into one fixed-width reset request pulse
module reset_request_ctrl #(
    parameter int DEBOUNCE_BITS  = 16,
    parameter int WDT_BITS       = 24,
    parameter int PULSE_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rstIn,
    reset_request_ctrl_if.slave  req_if
);
    localparam int MaxPhase = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int PhaseW   = $clog2(MaxPhase + 1);
    localparam logic [PhaseW-1:0] PulseLoad   = PhaseW'(PULSE_CYCLES - 1);
    localparam logic [PhaseW-1:0] HoldoffLoad = PhaseW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    logic                     btn_meta_q;
    logic                     btn_sync_q;
    logic                     btn_stable_q, btn_stable_d;
    logic                     btn_evt_q, btn_evt_d;
    logic [DEBOUNCE_BITS-1:0] deb_cnt_q, deb_cnt_d;
    logic [WDT_BITS-1:0]      wdt_cnt_q, wdt_cnt_d;
    logic                     wdt_evt;
    state_e                   state_q, state_d;
    logic [PhaseW-1:0]        phase_q, phase_d;
    logic                     rst_req_q;
    logic [2:0]               cause_q, cause_d;
    logic [2:0]               set_bits;

    // Stable level only follows the synced button after a full counter span of disagreement.
    always_comb begin
        deb_cnt_d    = '0;
        btn_stable_d = btn_stable_q;
        btn_evt_d    = 1'b0;
        if (btn_sync_q != btn_stable_q) begin
            if (&deb_cnt_q) begin
                btn_stable_d = btn_sync_q;
                btn_evt_d    = btn_sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // A kick in the terminal-count cycle suppresses the event.
    assign wdt_evt = req_if.wdtEn & ~req_if.wdtKick & (state_q == ST_IDLE) & (&wdt_cnt_q);

    always_comb begin
        wdt_cnt_d = wdt_cnt_q + 1'b1;
        if (!req_if.wdtEn || req_if.wdtKick || (state_q != ST_IDLE) || wdt_evt) begin
            wdt_cnt_d = '0;
        end
    end

    assign set_bits = {wdt_evt, req_if.swReq, btn_evt_q};

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cause_d = req_if.causeClr ? 3'b000 : cause_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|set_bits) begin
                    state_d = ST_ASSERT;
                    phase_d = PulseLoad;
                    cause_d = cause_d | set_bits;
                end
            end
            ST_ASSERT: begin
                if (phase_q == '0) begin
                    state_d = ST_HOLDOFF;
                    phase_d = HoldoffLoad;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (phase_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Power-on reset only; the cause register must survive the resets this block requests.
    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            btn_meta_q   <= 1'b0;
            btn_sync_q   <= 1'b0;
            btn_stable_q <= 1'b0;
            btn_evt_q    <= 1'b0;
            deb_cnt_q    <= '0;
            wdt_cnt_q    <= '0;
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            rst_req_q    <= 1'b0;
            cause_q      <= 3'b000;
        end else begin
            btn_meta_q   <= req_if.btnIn;
            btn_sync_q   <= btn_meta_q;
            btn_stable_q <= btn_stable_d;
            btn_evt_q    <= btn_evt_d;
            deb_cnt_q    <= deb_cnt_d;
            wdt_cnt_q    <= wdt_cnt_d;
            state_q      <= state_d;
            phase_q      <= phase_d;
            rst_req_q    <= (state_d == ST_ASSERT);
            cause_q      <= cause_d;
        end
    end

    assign req_if.rstReq = rst_req_q;
    assign req_if.cause  = cause_q;
    assign req_if.busy   = (state_q != ST_IDLE);
endmodule

// File: tb/tb_reset_request_ctrl.sv
// tb/tb_reset_request_ctrl.sv - randomized scoreboard bench for reset_request_ctrl
module tb_reset_request_ctrl;
    localparam int D = 3;
    localparam int W = 6;
    localparam int P = 4;
    localparam int H = 8;

    typedef struct {
        int         start;
        logic [2:0] cause;
    } exp_t;

    logic clk = 1'b0;
    logic rstIn;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    reset_request_ctrl_if rif ();

    reset_request_ctrl #(
        .DEBOUNCE_BITS (D),
        .WDT_BITS      (W),
        .PULSE_CYCLES  (P),
        .HOLDOFF_CYCLES(H)
    ) dut (
        .clk   (clk),
        .rstIn (rstIn),
        .req_if(rif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sbq[$];
    int   rise_cycles[$];

    // Reference model state
    bit         m_b1, m_b2, m_stable, m_pend;
    int         m_run, m_busy_end, m_wdt_last;
    logic [2:0] m_cause;
    bit         btn_lvl, en_lvl;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void model_reset(int c);
        m_b1 = 0; m_b2 = 0; m_stable = 0; m_pend = 0; m_run = 0;
        m_busy_end = -1000;
        m_wdt_last = c - 1;
        m_cause = 3'b000;
        sbq.delete();
    endfunction

    function automatic bit model_wdt_evt(int c, bit en, bit kick);
        return (c > m_busy_end) && en && !kick && ((c - m_wdt_last - 1) == (1 << W) - 1);
    endfunction

    // One cycle of the spec rules: inputs present in cycle c, effects visible after edge c+1.
    function automatic void model_step(int c);
        bit         idle, sync, bevt, wevt;
        logic [2:0] set;
        idle = (c > m_busy_end);
        sync = m_b2;
        m_b2 = m_b1;
        m_b1 = rif.btnIn;
        bevt = m_pend;
        m_pend = 0;
        if (sync != m_stable) begin
            m_run++;
            if (m_run == (1 << D)) begin
                m_stable = sync;
                m_run = 0;
                m_pend = sync;
            end
        end else begin
            m_run = 0;
        end
        wevt = model_wdt_evt(c, rif.wdtEn, rif.wdtKick);
        if (!rif.wdtEn || rif.wdtKick || !idle || wevt) m_wdt_last = c;
        set = idle ? {wevt, rif.swReq, bevt} : 3'b000;
        m_cause = (rif.causeClr ? 3'b000 : m_cause) | set;
        if (set != 3'b000) begin
            sbq.push_back('{c + 1, m_cause});
            m_busy_end = c + P + H;
        end
    endfunction

    function automatic void apply(bit sw, bit kick, bit clr);
        rif.btnIn    = btn_lvl;
        rif.swReq    = sw;
        rif.wdtEn    = en_lvl;
        rif.wdtKick  = kick;
        rif.causeClr = clr;
        model_step(cyc);
    endfunction

    task automatic step(bit sw, bit kick, bit clr);
        @(posedge clk);
        #1;
        apply(sw, kick, clr);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        btn_lvl = 0;
        en_lvl  = 0;
        model_reset(cyc);
        apply(0, 0, 0);
        #2 rstIn = 1'b0;
        #1;
        chk("post_reset_rstReq", int'(rif.rstReq), 0);
        chk("post_reset_busy", int'(rif.busy), 0);
        chk("post_reset_cause", int'(rif.cause), 0);
    endtask

    // Monitor: pops the scoreboard on every rstReq rise and checks pulse/busy widths.
    initial begin
        bit   prev_req, prev_busy, abort;
        int   req_len, busy_len;
        exp_t e;
        prev_req = 0; prev_busy = 0; abort = 1; req_len = 0; busy_len = 0;
        forever begin
            @(negedge clk);
            if (rstIn) begin
                abort = 1; prev_req = 0; prev_busy = 0; req_len = 0; busy_len = 0;
            end else begin
                if (rif.rstReq && !prev_req) begin
                    rise_cycles.push_back(cyc);
                    abort = 0;
                    req_len = 0;
                    chk("pulse_expected", int'(sbq.size() > 0), 1);
                    chk("busy_with_req", int'(rif.busy), 1);
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        chk("pulse_start_cycle", cyc, e.start);
                        chk("pulse_cause", int'(rif.cause), int'(e.cause));
                    end
                end
                if (rif.busy && !prev_busy) busy_len = 0;
                if (rif.rstReq) req_len++;
                if (rif.busy) busy_len++;
                if (!rif.rstReq && prev_req && !abort) chk("pulse_width", req_len, P);
                if (!rif.busy && prev_busy && !abort) chk("busy_width", busy_len, P + H);
                prev_req  = rif.rstReq;
                prev_busy = rif.busy;
            end
        end
    end

    initial begin
        int r0, c_sw, hold_c, k, n0;
        bit found;
        rstIn = 1'b1;
        btn_lvl = 0; en_lvl = 0;
        rif.btnIn = 0; rif.swReq = 0; rif.wdtEn = 0; rif.wdtKick = 0; rif.causeClr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rstReq", int'(rif.rstReq), 0);
        chk("reset_cause", int'(rif.cause), 0);
        chk("reset_busy", int'(rif.busy), 0);
        release_reset();

        // Software request, second request inside the busy window is dropped
        r0 = rise_cycles.size();
        repeat (8) step(0, 0, 0);
        step(1, 0, 0);
        c_sw = cyc;
        repeat (5) step(0, 0, 0);
        step(1, 0, 0);
        repeat (12) step(0, 0, 0);
        chk("sw_pulse_count", rise_cycles.size() - r0, 1);
        if (rise_cycles.size() > r0) chk("sw_rise_latency", rise_cycles[r0] - c_sw, 1);
        chk("sw_cause", int'(rif.cause), 2);

        // Button bounce then clean press and release
        step(0, 0, 1);
        r0 = rise_cycles.size();
        for (int i = 0; i < 50; i++) begin
            if (i % 3 == 0) btn_lvl = ~btn_lvl;
            step(0, 0, 0);
        end
        btn_lvl = 0;
        repeat (10) step(0, 0, 0);
        chk("btn_bounce_no_pulse", rise_cycles.size() - r0, 0);
        btn_lvl = 1;
        step(0, 0, 0);
        hold_c = cyc;
        repeat (30) step(0, 0, 0);
        chk("btn_pulse_count", rise_cycles.size() - r0, 1);
        if (rise_cycles.size() > r0) chk("btn_rise_latency", rise_cycles[r0] - hold_c, 11);
        chk("btn_cause", int'(rif.cause), 1);
        btn_lvl = 0;
        repeat (30) step(0, 0, 0);
        chk("btn_release_no_pulse", rise_cycles.size() - r0, 1);

        // Watchdog: kicked, then starved twice in a row
        step(0, 0, 1);
        en_lvl = 1;
        r0 = rise_cycles.size();
        k = 0;
        for (int i = 0; i < 500; i++) begin
            step(0, (i % 40) == 0, 0);
            if (i % 40 == 0) k = cyc;
        end
        chk("wdt_kicked_no_pulse", rise_cycles.size() - r0, 0);
        repeat (130) step(0, 0, 0);
        chk("wdt_pulse_count", rise_cycles.size() - r0, 2);
        if (rise_cycles.size() > r0) chk("wdt_rise_latency", rise_cycles[r0] - k, 65);
        if (rise_cycles.size() > r0 + 1)
            chk("wdt_rearm_period", rise_cycles[r0 + 1] - rise_cycles[r0], P + H + (1 << W));
        chk("wdt_cause", int'(rif.cause), 4);
        en_lvl = 0;

        // Software strobe in the watchdog terminal cycle
        step(0, 0, 1);
        en_lvl = 1;
        r0 = rise_cycles.size();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            found = model_wdt_evt(cyc, 1, 0);
            apply(found, 0, 0);
        end
        chk("sim_terminal_reached", int'(found), 1);
        en_lvl = 0;
        repeat (20) step(0, 0, 0);
        chk("sim_pulse_count", rise_cycles.size() - r0, 1);
        chk("sim_cause", int'(rif.cause), 6);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("clr_cause", int'(rif.cause), 0);

        // causeClr coinciding with a new acceptance
        btn_lvl = 1;
        repeat (25) step(0, 0, 0);
        chk("collide_pre_cause", int'(rif.cause), 1);
        step(1, 0, 1);
        step(0, 0, 0);
        chk("collide_cause", int'(rif.cause), 2);
        btn_lvl = 0;
        repeat (25) step(0, 0, 0);

        // Reset during the second ASSERT cycle
        step(1, 0, 0);
        step(0, 0, 0);
        @(posedge clk);
        #3 rstIn = 1'b1;
        #1;
        chk("async_drop_rstReq", int'(rif.rstReq), 0);
        chk("async_drop_busy", int'(rif.busy), 0);
        @(posedge clk);
        release_reset();
        n0 = rise_cycles.size();
        step(1, 0, 0);
        repeat (15) step(0, 0, 0);
        chk("after_reset_accept", rise_cycles.size() - n0, 1);

        // Randomized mix against the model
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            if (i % 50 == 0) chk("rand_cause", int'(rif.cause), int'(m_cause));
            if ($urandom_range(7) == 0) btn_lvl = ~btn_lvl;
            if ($urandom_range(99) == 0) en_lvl = ~en_lvl;
            apply($urandom_range(39) == 0, $urandom_range(49) == 0, $urandom_range(29) == 0);
        end
        btn_lvl = 0;
        en_lvl = 0;
        repeat (40) step(0, 0, 0);
        chk("final_cause", int'(rif.cause), int'(m_cause));
        chk("scoreboard_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reset_request_ctrl.md
# reset_request_ctrl

Collects system reset requests and turns them into one clean, width-guaranteed reset request pulse. Sources are a bouncing board button, a software strobe and an internal watchdog. The `rstReq` output drives the input side of the per-domain reset generator. The block itself runs from the always-present board clock and is reset only by power-on/board reset, so its sticky cause register survives the resets it requests.

## Interface
- `DEBOUNCE_BITS`, 16: debounce counter width; the button must be stable for 2^DEBOUNCE_BITS cycles.
- `WDT_BITS`, 24: watchdog counter width; timeout period is 2^WDT_BITS cycles.
- `PULSE_CYCLES`, 16: exact `rstReq` high time in cycles; must be ≥1.
- `HOLDOFF_CYCLES`, 64: dead time after the pulse during which requests are dropped; must be ≥1.

Ports:
- `clk`  in  1  block clock.
- `rstIn`  in  1  reset, asynchronous, active-high.
- `btnIn`  in  1  raw board button, asynchronous to `clk`, active-high.
- `swReq`  in  1  software reset request, single-cycle strobe.
- `wdtEn`  in  1  watchdog enable level.
- `wdtKick`  in  1  watchdog service strobe.
- `causeClr`  in  1  clears `cause`, single-cycle strobe.
- `rstReq`  out  1  registered reset request to the reset generator.
- `cause`  out  3  sticky reset cause: {wdt, sw, btn}.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- `rstIn` effect:
  - FSM to IDLE.
  - All outputs 0: `rstReq`=0, `cause`=3'b000, `busy`=0.
  - Sync flops, debounced level, debounce/watchdog/phase counters all cleared.
- Button path:
  - 2-flop synchronizer on `btnIn`.
  - Debounce counter increments while the synced value ≠ the stable level. It clears whenever they are equal.
  - When the counter is all-ones and the values still differ, the stable level takes the synced value and the counter clears.
  - A 0→1 change of the stable level produces a one-cycle `btnEvt`. The release edge produces nothing.
- Watchdog:
  - Counter clears when `wdtEn`=0, when `wdtKick`=1, or while the FSM is not IDLE.
  - Otherwise it increments each cycle.
  - When it is all-ones with `wdtEn`=1 and no kick, it produces one-cycle `wdtEvt` and wraps to 0.
  - A kick in the terminal-count cycle wins: no event.
- FSM states: IDLE, ASSERT, HOLDOFF. One phase counter, width clog2(max(PULSE_CYCLES, HOLDOFF_CYCLES)+1).
  - IDLE:
    - If any of `btnEvt`, `swReq` or `wdtEvt` is high, go to ASSERT and load PULSE_CYCLES-1.
    - On that same edge, OR the bits of all sources active in that cycle into `cause`.
  - ASSERT: decrement; at 0, go to HOLDOFF and load HOLDOFF_CYCLES-1.
  - HOLDOFF: decrement; at 0, go to IDLE.
- Requests arriving in ASSERT or HOLDOFF are dropped. They are not queued and do not update `cause`.
- `rstReq` is a registered flop, high exactly while in ASSERT. `busy` = (state ≠ IDLE).
- `cause`:
  - Sticky; cleared by `causeClr`.
  - If `causeClr` coincides with a new set, the new bits are written and all other bits clear (set wins per bit).

## Timing
- `swReq` high in cycle N:
  - `rstReq` rises at edge N+1 and stays high exactly PULSE_CYCLES cycles.
  - `rstReq` low, `busy` still high, for HOLDOFF_CYCLES cycles after that.
  - `busy` high for PULSE_CYCLES+HOLDOFF_CYCLES cycles total. The next request is accepted in the first cycle `busy`=0.
- Button: `btnEvt` fires 2 (sync) + 2^DEBOUNCE_BITS cycles after `btnIn` settles high. `rstReq` follows 1 cycle later. A glitch shorter than 2^DEBOUNCE_BITS synced cycles produces nothing.
- Watchdog: with `wdtEn` held and no kicks, `wdtEvt` fires 2^WDT_BITS cycles after the last clear. `rstReq` follows 1 cycle later.
- Simultaneous sources in IDLE: one pulse, multiple `cause` bits set.
- `rstIn` asserted mid-ASSERT: `rstReq` drops asynchronously. After release the FSM is in IDLE with `cause`=0.

## Test plan
Parameters for all scenarios: DEBOUNCE_BITS=3, WDT_BITS=6, PULSE_CYCLES=4, HOLDOFF_CYCLES=8.

- Software request: `swReq` pulse at cycle 10 → `rstReq` high cycles 11–14, `busy` high 11–22, `cause`=3'b010. A second `swReq` at cycle 16 is ignored and the counts are unchanged.
- Button debounce:
  - `btnIn` toggling every 3 cycles for 50 cycles → no `rstReq`.
  - Then held high → `rstReq` rises 11 cycles after the hold starts, `cause`=3'b001.
  - Release → no second pulse.
- Watchdog:
  - `wdtEn`=1 with a kick every 40 cycles for 500 cycles → no `rstReq`.
  - Stop kicking → `rstReq` rises 65 cycles after the last kick, `cause`=3'b100.
  - Watchdog counter stays 0 during the pulse and holdoff.
- Simultaneous sources: `swReq` and `wdtEvt` in the same IDLE cycle → exactly one 4-cycle pulse, `cause`=3'b110. `causeClr` with no set → 3'b000.
- Reset mid-pulse and clear/set collision:
  - `rstIn` during the 2nd ASSERT cycle → `rstReq`=0 immediately. After release: IDLE, `busy`=0, `cause`=0.
  - `causeClr` in the same cycle as a new `swReq` acceptance, with `cause`=3'b001 beforehand → `cause`=3'b010.
